// File: rtl/data_mem_requester.sv
// Single-access initiator for the stall-handshake data memory port: one strobe, then track stall high->low.
// Build with DATA_MEM_REQ_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of issuing them.
module data_mem_requester #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [3:0]        mem_sign_mask,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_clk_stall
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_STALL, WAIT_DONE, RESP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              is_write_q, is_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic              memread_q, memread_d;
  logic              memwrite_q, memwrite_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic       f3_ok, range_ok, req_bad, accept, timer_max;
  logic [3:0] req_mask;

  always_comb begin
    f3_ok    = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
               (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    range_ok = (req_addr >> ADDR_W) == 32'd0;
`ifdef DATA_MEM_REQ_MISALIGN_TRAP_EN
    req_bad  = ~f3_ok | ~range_ok |
               ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
               ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
`else
    req_bad  = ~f3_ok | ~range_ok;
`endif
    // {signed, word, half|word, 1}; stores never carry the signed bit
    req_mask = {~req_write & ~req_funct3[2] & ~req_funct3[1],
                req_funct3[1:0] == 2'b10,
                req_funct3[1:0] != 2'b00,
                1'b1};
  end

  assign req_ready = (state_q == IDLE) & ~mem_clk_stall;
  assign accept    = req_valid & req_ready;
  assign timer_max = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    is_write_d   = is_write_q;
    mem_addr_d   = mem_addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    memread_d    = 1'b0;
    memwrite_d   = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          is_write_d = req_write;
          if (req_bad) begin
            state_d = RESP;
          end else begin
            mem_addr_d = req_addr[ADDR_W-1:0];
            wdata_d    = req_wdata;
            mask_d     = req_mask;
            memread_d  = ~req_write;
            memwrite_d = req_write;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_STALL;
      end
      WAIT_STALL: begin
        if (timer_max) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
          if (mem_clk_stall) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (timer_max) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else if (!mem_clk_stall) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = is_write_q ? 32'd0 : mem_read_data;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        // Entered without a pulse only from a rejected request: emit the error now
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      is_write_q   <= 1'b0;
      mem_addr_q   <= '0;
      wdata_q      <= 32'd0;
      mask_q       <= 4'd0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      is_write_q   <= is_write_d;
      mem_addr_q   <= mem_addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = mask_q;
  assign mem_memread    = memread_q;
  assign mem_memwrite   = memwrite_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;

endmodule

// File: tb/tb_data_mem_requester.sv
// Randomized bench for data_mem_requester; expected per-cycle outputs come from a transaction-level model.
module tb_data_mem_requester;
  localparam int TIMEOUT = 16;
  localparam int ADDR_W  = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data, mem_read_data;
  logic              mem_memread, mem_memwrite, mem_clk_stall;
  logic [3:0]        mem_sign_mask;

  always #5 clk = ~clk;

  data_mem_requester #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall)
  );

  int tests = 0;
  int fails = 0;

  logic              chk_on = 1'b0;
  logic              exp_ready, exp_rd, exp_wr, exp_rv, exp_err, chk_mem;
  logic [31:0]       exp_rdata, exp_wdata;
  logic [ADDR_W-1:0] exp_addr;
  logic [3:0]        exp_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("memread", 32'(mem_memread), 32'(exp_rd));
      chk("memwrite", 32'(mem_memwrite), 32'(exp_wr));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (chk_mem) begin
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("mem_write_data", mem_write_data, exp_wdata);
        chk("mem_sign_mask", 32'(mem_sign_mask), 32'(exp_mask));
      end
      if (exp_rv) begin
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_rdata", resp_rdata, exp_rdata);
      end
    end
  end

  function automatic logic legal_of(input logic [2:0] f3, input logic [31:0] addr);
    logic ok;
    ok = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && (addr < (32'd1 << ADDR_W));
`ifdef DATA_MEM_REQ_MISALIGN_TRAP_EN
    if ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) ok = 1'b0;
    if (f3 == 3'b010 && addr[1:0] != 2'b00) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [3:0] mask_of(input logic wr, input logic [2:0] f3);
    case (f3)
      3'b000:  return wr ? 4'b0001 : 4'b1001;
      3'b001:  return wr ? 4'b0011 : 4'b1011;
      3'b010:  return 4'b0111;
      3'b100:  return 4'b0001;
      3'b101:  return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic set_idle();
    mem_clk_stall = 1'b0;
    exp_ready = 1'b1; exp_rd = 1'b0; exp_wr = 1'b0; exp_rv = 1'b0; chk_mem = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      set_idle();
    end
  endtask

  // Memory raises stall d1 cycles after seeing the strobe, holds it d2 cycles (d2==0: never stalls).
  // Called just after a posedge in an idle cycle; the request is accepted at the next edge.
  task automatic do_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int d1, input int d2, input int lit_mask, input int lit_resp);
    logic legal, er;
    int   rc;
    legal = legal_of(f3, addr);
    if (!legal) begin
      rc = 1; er = 1'b1;
    end else if (d2 == 0 || 2 + d1 + d2 > TIMEOUT) begin
      rc = TIMEOUT + 1; er = 1'b1;
    end else begin
      rc = 2 + d1 + d2; er = 1'b0;
    end
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_read_data = rdata;
    set_idle();
    for (int k = 0; k <= rc + 1; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      mem_clk_stall = legal && d2 > 0 && k >= 1 + d1 && k <= d1 + d2;
      exp_ready = (k > rc) && !mem_clk_stall;
      exp_rd    = legal && !wr && k == 0;
      exp_wr    = legal && wr && k == 0;
      chk_mem   = legal && k == 0;
      exp_addr  = addr[ADDR_W-1:0];
      exp_wdata = wdata;
      exp_mask  = mask_of(wr, f3);
      exp_rv    = (k == rc);
      exp_err   = er;
      exp_rdata = (!er && !wr) ? rdata : 32'd0;
      if (k == 0 && lit_mask >= 0) begin
        @(negedge clk);
        chk("lit_mask", 32'(mem_sign_mask), 32'(lit_mask));
      end
      if (k == lit_resp) begin
        @(negedge clk);
        chk("lit_resp_cycle", 32'(resp_valid), 32'd1);
      end
    end
  endtask

  task automatic do_rst_test();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1008;
    req_wdata = 32'h0; mem_read_data = 32'h1234_5678;
    set_idle();
    for (int k = 0; k <= 11; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_clk_stall = (k >= 1 && k <= 8);
      if (k == 3) rst = 1'b1;
      if (k == 4) rst = 1'b0;
      exp_rd = (k == 0); exp_wr = 1'b0; chk_mem = (k == 0); exp_rv = 1'b0;
      exp_addr = 14'h1008; exp_wdata = 32'h0; exp_mask = 4'b0111;
      exp_ready = (k >= 3) && !mem_clk_stall;
      if (k == 3) begin
        @(negedge clk);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_sign_mask", 32'(mem_sign_mask), 32'd0);
      end
      if (k == 6) begin
        @(negedge clk);
        chk("rst_ready_held", 32'(req_ready), 32'd0);
      end
      if (k == 9) begin
        @(negedge clk);
        chk("rst_ready_back", 32'(req_ready), 32'd1);
      end
    end
  endtask

  logic [2:0] st_f3 [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_read_data = 32'h0; mem_clk_stall = 1'b1;
    exp_ready = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_rv = 1'b0; exp_err = 1'b0; chk_mem = 1'b0;
    exp_rdata = 32'h0; exp_wdata = 32'h0; exp_addr = '0; exp_mask = 4'h0;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_sign_mask", 32'(mem_sign_mask), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    set_idle();
    idle(1);

    do_txn(1'b0, 3'b010, 32'h1004, 32'h0, 32'hDEAD_BEEF, 0, 2, 4'b0111, 4);
    do_txn(1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 2, 4'b0001, 4);
    do_txn(1'b0, 3'b001, 32'h1002, 32'h0, 32'hFFFF_8001, 0, 2, 4'b1011, 4);
    do_txn(1'b0, 3'b011, 32'h1002, 32'h0, 32'h5555_5555, 0, 2, -1, 1);
    do_txn(1'b0, 3'b010, 32'h0100, 32'h0, 32'h0BAD_0BAD, 0, 0, -1, TIMEOUT + 1);
    do_txn(1'b0, 3'b010, 32'h0001_0000, 32'h0, 32'h1, 0, 2, -1, 1);
    do_rst_test();
    do_txn(1'b0, 3'b010, 32'h1004, 32'h0, 32'hCAFE_F00D, 0, 2, 4'b0111, 4);
`ifdef DATA_MEM_REQ_MISALIGN_TRAP_EN
    do_txn(1'b0, 3'b010, 32'h1001, 32'h0, 32'h7, 0, 2, -1, 1);
`else
    do_txn(1'b0, 3'b010, 32'h1001, 32'h0, 32'h7, 0, 2, 4'b0111, 4);
`endif

    for (int t = 0; t < 150; t++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      wr   = 1'($urandom_range(0, 1));
      f3   = wr ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, (1 << ADDR_W) - 1));
      do_txn(wr, f3, addr, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(1, 5), -1, -1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(2);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
